// File: rtl/cache_pipe_stage_pkg.sv
// Shared types for the pipelined cache: packed control bundle, default widths
// and the elastic stage state encoding.
package pipelined_cache_types;

  typedef struct packed {
    logic        hit;
    logic        hit1;
    logic        dirty;
    logic        lru;
    logic        mem_write;
    logic        load_cache;
    logic [31:0] be0;
    logic [31:0] be1;
    logic [2:0]  set;
  } cache_ctrl_t;

  localparam int CACHE_CTRL_W = $bits(cache_ctrl_t);
  localparam int CACHE_DATA_W = 256;
  localparam int CACHE_ADDR_W = 32;

  // Encoding is {main_valid, skid_valid}; 01 cannot occur.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } stage_state_t;

endpackage

// File: rtl/cache_pipe_stage_entry.sv
// One held entry of the elastic stage: a valid bit plus payload register.
// Clear wins over load, and a cleared entry keeps its stale payload.
module cache_pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (clear)     valid <= 1'b0;
      else if (load) valid <= 1'b1;
      if (load && !clear) data <= load_data;
    end
  end

endmodule

// File: rtl/cache_pipe_stage.sv
// Elastic valid/ready stage register with a two-entry skid buffer, flush,
// stall history shift register and saturating stall-cycle counter.
module cache_pipe_stage
  import pipelined_cache_types::*;
#(
  parameter int DATA_W     = CACHE_DATA_W,
  parameter int ADDR_W     = CACHE_ADDR_W,
  parameter int CTRL_W     = CACHE_CTRL_W,
  parameter int STALL_HIST = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [CTRL_W-1:0]     in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [STALL_HIST-1:0] stall_hist,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int PW = DATA_W + ADDR_W + CTRL_W;

  logic          main_valid, skid_valid;
  logic [PW-1:0] main_payload, skid_payload, in_payload, main_wdata;
  logic          accept, drain, stall;
  logic          main_load, main_from_skid, skid_load;
  stage_state_t  state, next_state;

  assign in_payload = {in_data, in_addr, in_ctrl};
  assign in_ready   = ~skid_valid & ~flush;
  assign out_valid  = main_valid;
  assign accept     = in_valid & in_ready;
  assign drain      = main_valid & out_ready;
  assign stall      = main_valid & ~out_ready;
  assign occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};
  assign {out_data, out_addr, out_ctrl} = main_payload;
  assign main_wdata = main_from_skid ? skid_payload : in_payload;

  // The valid bits of the two entries form the state register; entries whose
  // bit is 0 in next_state are cleared, which also implements flush.
  always_comb begin
    state          = stage_state_t'({main_valid, skid_valid});
    next_state     = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          next_state = ST_ONE;
          main_load  = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_load = 1'b1;
        end else if (accept) begin
          next_state = ST_FULL;
          skid_load  = 1'b1;
        end else if (drain) begin
          next_state = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          next_state     = ST_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: next_state = ST_EMPTY;
    endcase
    if (flush) next_state = ST_EMPTY;
  end

  cache_pipe_entry #(.W(PW)) u_main (
    .clk       (clk),
    .rst       (rst),
    .clear     (~next_state[1]),
    .load      (main_load),
    .load_data (main_wdata),
    .valid     (main_valid),
    .data      (main_payload)
  );

  cache_pipe_entry #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (~next_state[0]),
    .load      (skid_load),
    .load_data (in_payload),
    .valid     (skid_valid),
    .data      (skid_payload)
  );

  // History and counter survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_hist <= '0;
      stall_cnt  <= '0;
    end else begin
      stall_hist <= (stall_hist << 1) | STALL_HIST'(stall);
      if (stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_pipe_stage.sv
// Directed self-checking bench for cache_pipe_stage: default-width instance
// plus a narrow CNT_W=3 instance for counter saturation.
module tb_cache_pipe_stage;
  import pipelined_cache_types::*;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [255:0] in_data, out_data;
  logic [31:0]  in_addr, out_addr;
  logic [72:0]  in_ctrl, out_ctrl;
  logic [1:0]   stall_hist, occupancy;
  logic [15:0]  stall_cnt;

  logic         s_flush, s_in_valid, s_out_ready, s_in_ready, s_out_valid;
  logic [7:0]   s_in_data, s_out_data, s_in_addr, s_out_addr;
  logic [3:0]   s_in_ctrl, s_out_ctrl;
  logic [1:0]   s_stall_hist, s_occupancy;
  logic [2:0]   s_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_pipe_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_addr(in_addr), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_ctrl(out_ctrl),
    .stall_hist(stall_hist), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  cache_pipe_stage #(.DATA_W(8), .ADDR_W(8), .CTRL_W(4), .STALL_HIST(2), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_addr(s_in_addr), .in_ctrl(s_in_ctrl),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_addr(s_out_addr), .out_ctrl(s_out_ctrl),
    .stall_hist(s_stall_hist), .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  function automatic logic [255:0] data_of(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [72:0] ctrl_of(input logic [31:0] a);
    return {a[8:0], 32'hFFFF_0000 | a, a};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a);
    in_valid = v;
    in_addr  = a;
    in_data  = data_of(a);
    in_ctrl  = ctrl_of(a);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; drive(1'b0, 32'h0);
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    s_in_data = 8'h0; s_in_addr = 8'h0; s_in_ctrl = 4'h0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
  endtask

  // Leaves the stage FULL holding 0x100 (main) and 0x120 (skid); one stall cycle counted.
  task automatic fill_full();
    out_ready = 1'b1; drive(1'b1, 32'h100); cyc();
    out_ready = 1'b0; drive(1'b1, 32'h120); cyc();
    drive(1'b0, 32'h0); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL reset_occupancy got %0d want 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (stall_cnt !== 16'd0 || stall_hist !== 2'b00) begin errors++; $display("[TB] FAIL reset_stall got cnt=%0d hist=%b want 0/00", stall_cnt, stall_hist); end
    checks++; if (out_addr !== 32'h0 || out_data !== 256'h0) begin errors++; $display("[TB] FAIL reset_payload got addr=%h want 0", out_addr); end
  endtask

  task automatic test_streaming();
    logic [31:0] addrs [3] = '{32'h100, 32'h120, 32'h140};
    do_reset();
    out_ready = 1'b1;
    foreach (addrs[i]) begin
      drive(1'b1, addrs[i]);
      cyc();
      checks++; if (out_valid !== 1'b1 || out_addr !== addrs[i] || out_data !== data_of(addrs[i]) || out_ctrl !== ctrl_of(addrs[i]))
        begin errors++; $display("[TB] FAIL stream_out[%0d] got v=%0b addr=%h want 1/%h", i, out_valid, out_addr, addrs[i]); end
      checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1)
        begin errors++; $display("[TB] FAIL stream_occ[%0d] got occ=%0d rdy=%0b want 1/1", i, occupancy, in_ready); end
    end
    drive(1'b0, 32'h0); cyc();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || stall_cnt !== 16'd0)
      begin errors++; $display("[TB] FAIL stream_drain got occ=%0d v=%0b cnt=%0d want 0/0/0", occupancy, out_valid, stall_cnt); end
  endtask

  task automatic test_skid_fill();
    do_reset();
    fill_full();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_addr !== 32'h100)
      begin errors++; $display("[TB] FAIL skid_full got occ=%0d rdy=%0b addr=%h want 2/0/100", occupancy, in_ready, out_addr); end
    cyc();
    checks++; if (out_addr !== 32'h100 || out_valid !== 1'b1)
      begin errors++; $display("[TB] FAIL skid_hold got addr=%h v=%0b want 100/1", out_addr, out_valid); end
    // Drain while a new beat waits: 0x140 must be refused until the skid empties.
    out_ready = 1'b1; drive(1'b1, 32'h140); cyc();
    checks++; if (out_addr !== 32'h120 || out_data !== data_of(32'h120) || occupancy !== 2'd1 || in_ready !== 1'b1)
      begin errors++; $display("[TB] FAIL skid_drain got addr=%h occ=%0d rdy=%0b want 120/1/1", out_addr, occupancy, in_ready); end
    cyc();
    drive(1'b0, 32'h0);
    checks++; if (out_addr !== 32'h140 || occupancy !== 2'd1)
      begin errors++; $display("[TB] FAIL skid_next got addr=%h occ=%0d want 140/1", out_addr, occupancy); end
    cyc();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      begin errors++; $display("[TB] FAIL skid_empty got v=%0b occ=%0d want 0/0", out_valid, occupancy); end
  endtask

  task automatic test_stall_count();
    do_reset();
    drive(1'b1, 32'h300); cyc();
    drive(1'b0, 32'h0);
    repeat (5) cyc();
    checks++; if (stall_cnt !== 16'd5 || stall_hist !== 2'b11)
      begin errors++; $display("[TB] FAIL stall_5 got cnt=%0d hist=%b want 5/11", stall_cnt, stall_hist); end
    out_ready = 1'b1; cyc();
    checks++; if (stall_cnt !== 16'd5 || stall_hist !== 2'b10 || occupancy !== 2'd0)
      begin errors++; $display("[TB] FAIL stall_release got cnt=%0d hist=%b occ=%0d want 5/10/0", stall_cnt, stall_hist, occupancy); end
    do_reset();
    s_in_valid = 1'b1; s_in_addr = 8'h3C; s_in_data = 8'hA7; s_in_ctrl = 4'h9; cyc();
    s_in_valid = 1'b0;
    checks++; if (s_out_addr !== 8'h3C || s_out_data !== 8'hA7 || s_out_ctrl !== 4'h9 || s_occupancy !== 2'd1)
      begin errors++; $display("[TB] FAIL narrow_load got addr=%h occ=%0d want 3c/1", s_out_addr, s_occupancy); end
    repeat (10) cyc();
    checks++; if (s_stall_cnt !== 3'd7 || s_stall_hist !== 2'b11 || s_out_valid !== 1'b1 || s_in_ready !== 1'b1)
      begin errors++; $display("[TB] FAIL stall_saturate got cnt=%0d hist=%b want 7/11", s_stall_cnt, s_stall_hist); end
  endtask

  task automatic test_flush();
    do_reset();
    fill_full();
    flush = 1'b1; drive(1'b1, 32'h200); #1;
    checks++; if (in_ready !== 1'b0)
      begin errors++; $display("[TB] FAIL flush_in_ready got %0b want 0", in_ready); end
    cyc();
    flush = 1'b0; drive(1'b0, 32'h0); #1;
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("[TB] FAIL flush_empty got occ=%0d v=%0b rdy=%0b want 0/0/1", occupancy, out_valid, in_ready); end
    checks++; if (stall_cnt !== 16'd2 || stall_hist !== 2'b11)
      begin errors++; $display("[TB] FAIL flush_keeps_stats got cnt=%0d hist=%b want 2/11", stall_cnt, stall_hist); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (out_valid !== 1'b0)
        begin errors++; $display("[TB] FAIL flush_no_emerge[%0d] got v=%0b addr=%h want 0", i, out_valid, out_addr); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1; drive(1'b1, 32'h100); cyc();
    drive(1'b1, 32'h140); cyc();
    drive(1'b0, 32'h0);
    checks++; if (out_addr !== 32'h140 || out_ctrl !== ctrl_of(32'h140) || occupancy !== 2'd1)
      begin errors++; $display("[TB] FAIL b2b got addr=%h occ=%0d want 140/1", out_addr, occupancy); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    fill_full();
    cyc(); cyc();
    checks++; if (stall_cnt !== 16'd3 || occupancy !== 2'd2)
      begin errors++; $display("[TB] FAIL midrst_pre got cnt=%0d occ=%0d want 3/2", stall_cnt, occupancy); end
    rst = 1'b1; flush = 1'b1; drive(1'b1, 32'h400); out_ready = 1'b1; cyc();
    rst = 1'b0; flush = 1'b0; drive(1'b0, 32'h0); out_ready = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 16'd0 || stall_hist !== 2'b00)
      begin errors++; $display("[TB] FAIL midrst got v=%0b occ=%0d cnt=%0d hist=%b want 0/0/0/00", out_valid, occupancy, stall_cnt, stall_hist); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid_fill();
    test_stall_count();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_pipe_stage.md
Name: cache_pipe_stage

Overview:
Parametrised elastic stage register for the pipelined cache, placed between tag-compare and data-access stages and reusable between any two cache stages. It replaces the bare load/stall register bank with a valid/ready handshake and a two-entry skid buffer, so a downstream stall never drops or duplicates a request. It also adds a synchronous flush, a configurable-depth stall history and a saturating stall-cycle counter.

Parameters:
DATA_W, 256, width of line data field (rdata/wdata bundle per beat)
ADDR_W, 32, width of request address field
CTRL_W, 73, width of packed control field (cache_ctrl_t: hit, hit1, dirty, lru, mem_write, load_cache, be0[31:0], be1[31:0], set[2:0])
STALL_HIST, 2, depth of stall history shift register (>=1)
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
flush  in  1  discard all held entries this cycle
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept; combinational: ~skid_valid & ~flush
in_data  in  DATA_W  upstream data
in_addr  in  ADDR_W  upstream address
in_ctrl  in  CTRL_W  upstream control bundle
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  main entry data
out_addr  out  ADDR_W  main entry address
out_ctrl  out  CTRL_W  main entry control
stall_hist  out  STALL_HIST  bit k = stall occurred k+1 cycles ago
occupancy  out  2  entries held: 0, 1 or 2
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: all valid bits, data/addr/ctrl regs, stall_hist and stall_cnt are 0. out_valid=0, occupancy=0, in_ready=1.
- accept = in_valid & in_ready. drain = out_valid & out_ready. stall = out_valid & ~out_ready.
- Latency is 1 cycle: a beat accepted in cycle N appears on out_* in N+1 when the stage was empty or drained in N.
- States, encoded as {main_valid, skid_valid}:
  - EMPTY (00): accept -> ONE, beat written to main.
  - ONE (10): accept&drain -> ONE, main overwritten. accept&~drain -> FULL, beat written to skid. ~accept&drain -> EMPTY. Otherwise ONE.
  - FULL (11): in_ready=0. drain -> ONE, skid copied to main. Otherwise FULL.
- Data/addr/ctrl registers load only when their entry is written. While stalled, out_* holds stable, and out_valid never drops without drain or flush.
- Order is FIFO: the skid entry always reaches out_* after main. No beat is lost or duplicated.
- flush: priority over all. Next state EMPTY. in_ready=0 in the flush cycle, so no beat is accepted. Payload regs keep stale values, but valids are 0.
- stall_hist: every cycle, shift left with stall in bit 0. Flush does not clear it; rst does.
- stall_cnt: +1 per cycle with stall=1. Saturates at 2^CNT_W-1. Cleared only by rst.
- occupancy = main_valid + skid_valid.
- Reset mid-operation: rst overrides flush and handshakes. Held beats are discarded; the counter and history are cleared.

Decomposition:
- Package pipelined_cache_types holds cache_ctrl_t (packed struct above), CACHE_CTRL_W = $bits(cache_ctrl_t) and the default DATA_W/ADDR_W constants.
- One natural sub-module, cache_pipe_entry: a valid bit plus payload register with write-enable and clear. It is instantiated twice (main, skid). The top holds the state control, history and counter.

Test Plan:
- Reset then streaming: out_ready=1; addrs 0x100, 0x120, 0x140 on consecutive cycles -> each appears one cycle later; occupancy stays 1; in_ready stays 1; stall_cnt=0.
- Skid fill: in ONE holding 0x100, drop out_ready; send 0x120 -> occupancy=2, in_ready=0, out_addr holds 0x100; raise out_ready -> 0x100 then 0x120 on consecutive cycles.
- Stall counting: hold stall for 5 cycles -> stall_cnt=5, stall_hist=2'b11; next cycle no stall -> stall_hist=2'b10. With CNT_W=3 and a 10-cycle stall -> stall_cnt=7.
- Flush in FULL with in_valid=1 and addr 0x200 -> next cycle occupancy=0, out_valid=0, in_ready=1; 0x200 never emerges.
- Simultaneous accept+drain in ONE: main 0x100, input 0x140, out_ready=1 -> next cycle out_addr=0x140, occupancy=1.
- Mid-operation rst in FULL after 3 stall cycles -> next cycle out_valid=0, occupancy=0, stall_cnt=0, stall_hist=0.
